rvvi_ack_rx: RTL and testbench



---
 rtl/rvvi_pkg.sv | 46 ++++
 rtl/rvvi_ack_rx_if.sv | 33 +++
 rtl/rvvi_ack_stallctl.sv | 82 ++++++++
 rtl/rvvi_ack_rx.sv | 188 ++++++++++++++++++
 tb/tb_rvvi_ack_rx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvvi_pkg.sv
// ----------------------------------------------------------------------------
// rvvi_pkg
// Shared definitions for the RVVI acknowledge receiver:
//   - ack_state_e      : frame parser states
//   - ACK_FRAME_WORDS  : number of 32-bit words in an acknowledge frame
//   - word/bit offsets for the EtherType, Minstret and HostLoad fields
//   - helpers that assemble Minstret/HostLoad from their word slices
// ----------------------------------------------------------------------------
package rvvi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } ack_state_e;

    localparam int ACK_FRAME_WORDS = 7;
    localparam logic [2:0] LAST_WORD_IDX = 3'(ACK_FRAME_WORDS - 1);

    // EtherType lives in the low half of word 3
    localparam int ETYPE_WORD = 3;
    localparam int ETYPE_MSB  = 15;
    localparam int ETYPE_LSB  = 0;

    // Minstret straddles words 3..5: {W5[15:0], W4, W3[31:16]}
    localparam int MINSTRET_LO_WORD  = 3;
    localparam int MINSTRET_MID_WORD = 4;
    localparam int MINSTRET_HI_WORD  = 5;

    // HostLoad straddles words 5..6: {W6[15:0], W5[31:16]}
    localparam int LOAD_LO_WORD = 5;
    localparam int LOAD_HI_WORD = 6;

    function automatic logic [63:0] ack_minstret_field(input logic [15:0] hi,
                                                       input logic [31:0] mid,
                                                       input logic [15:0] lo);
        return {hi, mid, lo};
    endfunction

    function automatic logic [31:0] ack_load_field(input logic [15:0] hi,
                                                   input logic [15:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/rvvi_ack_rx_if.sv
// ----------------------------------------------------------------------------
// rvvi_ack_rx_if
// 32-bit AXI-stream receive channel from the MAC receive FIFO.
//   RxTdata  : beat data, byte 0 in [7:0]
//   RxTkeep  : byte enables (not used by the receiver)
//   RxTvalid : beat valid
//   RxTlast  : last beat of the frame
//   RxTready : sink ready
// Modports: master (MAC FIFO side), slave (acknowledge receiver side).
// ----------------------------------------------------------------------------
interface rvvi_ack_rx_if;
    logic [31:0] RxTdata;
    logic [3:0]  RxTkeep;
    logic        RxTvalid;
    logic        RxTlast;
    logic        RxTready;

    modport master (
        output RxTdata,
        output RxTkeep,
        output RxTvalid,
        output RxTlast,
        input  RxTready
    );

    modport slave (
        input  RxTdata,
        input  RxTkeep,
        input  RxTvalid,
        input  RxTlast,
        output RxTready
    );
endinterface

// File: rtl/rvvi_ack_stallctl.sv
// ----------------------------------------------------------------------------
// rvvi_ack_stallctl
// Throttle decision for the RVVI transmitter.
//   sent_minstret  (in)  : Minstret of the latest frame sent by acev
//   ack_minstret   (in)  : Minstret last acknowledged by the host
//   host_load      (in)  : last host load report
//   ack_valid      (in)  : accepted-frame pulse
//   external_stall (out) : registered stall request
//   ack_timeout    (out) : sticky timeout flag
//   resync         (out) : one-cycle request to reload ack state from sent
// Optional macro RVVI_ACK_TIMEOUT_EN enables the stall timeout/resync;
// without it ack_timeout is 0 and a stall holds until the host catches up.
// ----------------------------------------------------------------------------
module rvvi_ack_stallctl #(
    parameter logic [63:0] MAX_OUTSTANDING = 64'd64,
    parameter logic [31:0] LOAD_THRESHOLD  = 32'hC000_0000,
    parameter logic [31:0] ACK_TIMEOUT     = 32'd100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] sent_minstret,
    input  logic [63:0] ack_minstret,
    input  logic [31:0] host_load,
    input  logic        ack_valid,
    output logic        external_stall,
    output logic        ack_timeout,
    output logic        resync
);

    logic [63:0] outstanding_s;
    logic        stall_nxt_s;
    logic        stall_r;

    // Modulo subtraction keeps the distance correct across Minstret wrap
    assign outstanding_s = sent_minstret - ack_minstret;
    assign stall_nxt_s   = (outstanding_s >= MAX_OUTSTANDING) | (host_load > LOAD_THRESHOLD);

    // Stall request register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r <= 1'b0;
        end else begin
            stall_r <= stall_nxt_s;
        end
    end

    assign external_stall = stall_r;

`ifdef RVVI_ACK_TIMEOUT_EN
    logic [31:0] timer_r;
    logic        timeout_r;
    logic        hit_s;

    // timer_r counts stall cycles already elapsed, so the current cycle is
    // the ACK_TIMEOUT-th one when timer_r == ACK_TIMEOUT-1
    assign hit_s = stall_r & ~ack_valid & (timer_r == (ACK_TIMEOUT - 32'd1));

    // Stall duration counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r   <= 32'd0;
            timeout_r <= 1'b0;
        end else if (ack_valid || !stall_r) begin
            timer_r   <= 32'd0;
        end else if (hit_s) begin
            timer_r   <= 32'd0;
            timeout_r <= 1'b1;
        end else begin
            timer_r   <= timer_r + 32'd1;
        end
    end

    assign ack_timeout = timeout_r;
    assign resync      = hit_s;
`else
    logic unused_s;
    assign unused_s    = ack_valid ^ (^ACK_TIMEOUT);
    assign ack_timeout = 1'b0;
    assign resync      = 1'b0;
`endif

endmodule

// File: rtl/rvvi_ack_rx.sv
// ----------------------------------------------------------------------------
// rvvi_ack_rx
// Parses 7-word host acknowledge frames from the MAC AXI-stream receive port,
// extracts the acknowledged Minstret and host load, and drives ExternalStall.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   rx             : AXI-stream receive channel (slave modport, always ready)
//   SentMinstret   : Minstret of the latest frame sent by acev
//   AckMinstret    : last acknowledged Minstret
//   HostLoad       : last reported host load
//   AckValid       : one-cycle pulse per accepted frame
//   ExternalStall  : stall request to the core/acev
//   GoodFrameCount : accepted frames (wraps)
//   BadFrameCount  : rejected frames (wraps)
//   AckTimeout     : sticky stall-timeout flag
// Optional macro RVVI_ACK_TIMEOUT_EN enables the stall timeout/resync.
// ----------------------------------------------------------------------------
module rvvi_ack_rx
    import rvvi_pkg::*;
#(
    parameter logic [15:0] ETHER_TYPE      = 16'h88B5,
    parameter logic [63:0] MAX_OUTSTANDING = 64'd64,
    parameter logic [31:0] LOAD_THRESHOLD  = 32'hC000_0000,
    parameter logic [31:0] ACK_TIMEOUT     = 32'd100000
) (
    input  logic                clk,
    input  logic                reset,
    rvvi_ack_rx_if.slave        rx,
    input  logic [63:0]         SentMinstret,
    output logic [63:0]         AckMinstret,
    output logic [31:0]         HostLoad,
    output logic                AckValid,
    output logic                ExternalStall,
    output logic [15:0]         GoodFrameCount,
    output logic [15:0]         BadFrameCount,
    output logic                AckTimeout
);

    ack_state_e  state_r, state_nxt_s;
    logic [2:0]  cnt_r, cnt_nxt_s;
    logic [31:0] w_r [ACK_FRAME_WORDS];
    logic        cap_en_s;
    logic [2:0]  cap_idx_s;
    logic        bad_frame_s;   // short/overlong frame or 1-beat frame
    logic        commit_s;
    logic        etype_ok_s;
    logic        good_s;
    logic        bad_etype_s;
    logic [1:0]  bad_inc_s;
    logic        resync_s;
    logic        unused_s;

    assign rx.RxTready = 1'b1;

    // Address words, the top of W6 and the keep bits carry nothing we use
    assign unused_s = ^{w_r[0], w_r[1], w_r[2], w_r[LOAD_HI_WORD][31:16], rx.RxTkeep};

    // Parser state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Parser next-state and beat capture control
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cap_en_s    = 1'b0;
        cap_idx_s   = 3'd0;
        bad_frame_s = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_COMMIT: begin
                commit_s = (state_r == ST_COMMIT);
                // A beat during COMMIT already belongs to the next frame
                if (rx.RxTvalid) begin
                    cap_en_s  = 1'b1;
                    cap_idx_s = 3'd0;
                    cnt_nxt_s = 3'd1;
                    if (rx.RxTlast) begin
                        bad_frame_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RECV;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (rx.RxTvalid) begin
                    cap_en_s  = 1'b1;
                    cap_idx_s = cnt_r;
                    if (cnt_r == LAST_WORD_IDX) begin
                        state_nxt_s = rx.RxTlast ? ST_COMMIT : ST_DRAIN;
                    end else if (rx.RxTlast) begin
                        bad_frame_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_DRAIN: begin
                if (rx.RxTvalid && rx.RxTlast) begin
                    bad_frame_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame word capture
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ACK_FRAME_WORDS; i++) begin
                w_r[i] <= 32'd0;
            end
        end else if (cap_en_s) begin
            for (int i = 0; i < ACK_FRAME_WORDS; i++) begin
                if (cap_idx_s == 3'(i)) begin
                    w_r[i] <= rx.RxTdata;
                end
            end
        end
    end

    assign etype_ok_s  = (w_r[ETYPE_WORD][ETYPE_MSB:ETYPE_LSB] == ETHER_TYPE);
    assign good_s      = commit_s & etype_ok_s;
    assign bad_etype_s = commit_s & ~etype_ok_s;
    // An EtherType reject and a 1-beat frame can land in the same cycle
    assign bad_inc_s   = {1'b0, bad_frame_s} + {1'b0, bad_etype_s};

    // Acknowledge fields, pulse and frame counters
    always_ff @(posedge clk) begin
        if (reset) begin
            AckMinstret    <= 64'd0;
            HostLoad       <= 32'd0;
            AckValid       <= 1'b0;
            GoodFrameCount <= 16'd0;
            BadFrameCount  <= 16'd0;
        end else begin
            AckValid      <= good_s;
            BadFrameCount <= BadFrameCount + {14'd0, bad_inc_s};
            if (good_s) begin
                AckMinstret    <= ack_minstret_field(w_r[MINSTRET_HI_WORD][15:0],
                                                     w_r[MINSTRET_MID_WORD],
                                                     w_r[MINSTRET_LO_WORD][31:16]);
                HostLoad       <= ack_load_field(w_r[LOAD_HI_WORD][15:0],
                                                 w_r[LOAD_LO_WORD][31:16]);
                GoodFrameCount <= GoodFrameCount + 16'd1;
            end else if (resync_s) begin
                // Give up waiting on the host: treat everything sent as acked
                AckMinstret <= SentMinstret;
                HostLoad    <= 32'd0;
            end
        end
    end

    rvvi_ack_stallctl #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .LOAD_THRESHOLD  (LOAD_THRESHOLD),
        .ACK_TIMEOUT     (ACK_TIMEOUT)
    ) u_stallctl (
        .clk            (clk),
        .reset          (reset),
        .sent_minstret  (SentMinstret),
        .ack_minstret   (AckMinstret),
        .host_load      (HostLoad),
        .ack_valid      (AckValid),
        .external_stall (ExternalStall),
        .ack_timeout    (AckTimeout),
        .resync         (resync_s)
    );

endmodule

// File: tb/tb_rvvi_ack_rx.sv
// ----------------------------------------------------------------------------
// tb_rvvi_ack_rx
// Directed frames into rvvi_ack_rx. Expected acknowledges are queued when a
// good frame is sent; a monitor pops and compares on every AckValid. Counter,
// stall and reset checks are made inline by the stimulus process.
// ----------------------------------------------------------------------------
module tb_rvvi_ack_rx;

`ifdef RVVI_ACK_TIMEOUT_EN
    localparam logic [31:0] TB_ACK_TIMEOUT = 32'd10;
`else
    localparam logic [31:0] TB_ACK_TIMEOUT = 32'd100000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] SentMinstret;
    logic [63:0] AckMinstret;
    logic [31:0] HostLoad;
    logic        AckValid;
    logic        ExternalStall;
    logic [15:0] GoodFrameCount;
    logic [15:0] BadFrameCount;
    logic        AckTimeout;

    rvvi_ack_rx_if rx_if ();

    rvvi_ack_rx #(
        .ETHER_TYPE      (16'h88B5),
        .MAX_OUTSTANDING (64'd64),
        .LOAD_THRESHOLD  (32'hC000_0000),
        .ACK_TIMEOUT     (TB_ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx_if),
        .SentMinstret   (SentMinstret),
        .AckMinstret    (AckMinstret),
        .HostLoad       (HostLoad),
        .AckValid       (AckValid),
        .ExternalStall  (ExternalStall),
        .GoodFrameCount (GoodFrameCount),
        .BadFrameCount  (BadFrameCount),
        .AckTimeout     (AckTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] minstret;
        logic [31:0] load;
        logic [15:0] good;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] m, input logic [31:0] l, input logic [15:0] g);
        exp_t e;
        e.minstret = m;
        e.load     = l;
        e.good     = g;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every AckValid cycle consumes one expected ack
    always @(negedge clk) begin
        if (AckValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=AckValid(minstret=%h) expected=none", AckMinstret);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_minstret", AckMinstret, mon_e.minstret);
                chk("ack_load", {32'd0, HostLoad}, {32'd0, mon_e.load});
                chk("ack_good_count", {48'd0, GoodFrameCount}, {48'd0, mon_e.good});
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic last);
        @(negedge clk);
        rx_if.RxTvalid = 1'b1;
        rx_if.RxTdata  = d;
        rx_if.RxTlast  = last;
        rx_if.RxTkeep  = 4'hF;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_if.RxTvalid = 1'b0;
            rx_if.RxTlast  = 1'b0;
        end
    endtask

    // n beats; words 3..6 from arguments, anything else is filler
    task automatic frame(input int n, input logic [31:0] w3, input logic [31:0] w4,
                         input logic [31:0] w5, input logic [31:0] w6);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            case (i)
                3:       d = w3;
                4:       d = w4;
                5:       d = w5;
                6:       d = w6;
                default: d = 32'hA0A0_0000 | 32'(i);
            endcase
            beat(d, (i == n - 1));
        end
    endtask

    // Returns at the negedge where AckValid is seen, or reports a timeout
    task automatic wait_ack(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            rx_if.RxTvalid = 1'b0;
            rx_if.RxTlast  = 1'b0;
            if (AckValid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s actual=no_AckValid expected=AckValid_within_12_cycles", name);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ack_minstret"}, AckMinstret, 64'd0);
        chk({tag, "_host_load"}, {32'd0, HostLoad}, 64'd0);
        chk({tag, "_ack_valid"}, {63'd0, AckValid}, 64'd0);
        chk({tag, "_stall"}, {63'd0, ExternalStall}, 64'd0);
        chk({tag, "_good"}, {48'd0, GoodFrameCount}, 64'd0);
        chk({tag, "_bad"}, {48'd0, BadFrameCount}, 64'd0);
        chk({tag, "_timeout"}, {63'd0, AckTimeout}, 64'd0);
        chk({tag, "_tready"}, {63'd0, rx_if.RxTready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        rx_if.RxTvalid = 1'b0;
        rx_if.RxTlast  = 1'b0;
        rx_if.RxTdata  = 32'd0;
        rx_if.RxTkeep  = 4'h0;
        SentMinstret   = 64'h0000_0000_0001_1234;
        repeat (2) @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b0;

        // 1: good frame
        push_exp(64'h0000_0000_0001_1234, 32'h0000_0050, 16'd1);
        frame(7, 32'h1234_88B5, 32'h0000_0001, 32'h0050_0000, 32'h0000_0000);
        wait_ack("t1");
        idle(2);
        chk("t1_good", {48'd0, GoodFrameCount}, 64'd1);
        chk("t1_bad", {48'd0, BadFrameCount}, 64'd0);
        chk("t1_stall", {63'd0, ExternalStall}, 64'd0);

        // 2: outstanding 100-36=64 stalls, 100-37=63 releases
        SentMinstret = 64'd100;
        push_exp(64'd36, 32'd0, 16'd2);
        frame(7, 32'h0024_88B5, 32'd0, 32'd0, 32'd0);
        wait_ack("t2a");
        @(negedge clk);
        chk("t2_stall_on", {63'd0, ExternalStall}, 64'd1);
        push_exp(64'd37, 32'd0, 16'd3);
        frame(7, 32'h0025_88B5, 32'd0, 32'd0, 32'd0);
        wait_ack("t2b");
        chk("t2_stall_hold", {63'd0, ExternalStall}, 64'd1);
        @(negedge clk);
        chk("t2_stall_off", {63'd0, ExternalStall}, 64'd0);

        // 3: short, long, then good
        frame(5, 32'h0099_88B5, 32'd0, 32'd0, 32'd0);
        idle(3);
        chk("t3_short_bad", {48'd0, BadFrameCount}, 64'd1);
        chk("t3_short_ack", AckMinstret, 64'd37);
        frame(9, 32'h0099_88B5, 32'd0, 32'd0, 32'd0);
        idle(3);
        chk("t3_long_bad", {48'd0, BadFrameCount}, 64'd2);
        push_exp(64'd38, 32'd0, 16'd4);
        frame(7, 32'h0026_88B5, 32'd0, 32'd0, 32'd0);
        wait_ack("t3");
        idle(1);
        chk("t3_bad_after_good", {48'd0, BadFrameCount}, 64'd2);

        // 4: wrong EtherType
        frame(7, 32'h0027_0800, 32'd0, 32'h1111_0000, 32'd0);
        idle(3);
        chk("t4_bad", {48'd0, BadFrameCount}, 64'd3);
        chk("t4_ack", AckMinstret, 64'd38);
        chk("t4_load", {32'd0, HostLoad}, 64'd0);
        chk("t4_good", {48'd0, GoodFrameCount}, 64'd4);

        // 5: back-to-back, then high load
        push_exp(64'd39, 32'd0, 16'd5);
        push_exp(64'd40, 32'd0, 16'd6);
        frame(7, 32'h0027_88B5, 32'd0, 32'd0, 32'd0);
        frame(7, 32'h0028_88B5, 32'd0, 32'd0, 32'd0);
        idle(4);
        chk("t5_good", {48'd0, GoodFrameCount}, 64'd6);
        chk("t5_ack", AckMinstret, 64'd40);
        chk("t5_stall_low", {63'd0, ExternalStall}, 64'd0);
        push_exp(64'd41, 32'hFFFF_0000, 16'd7);
        frame(7, 32'h0029_88B5, 32'd0, 32'h0000_0000, 32'h0000_FFFF);
        wait_ack("t5_load");
        @(negedge clk);
        chk("t5_stall_load", {63'd0, ExternalStall}, 64'd1);

        // 6: reset during word 3, tail becomes a short frame
        beat(32'hB000_0000, 1'b0);
        beat(32'hB000_0001, 1'b0);
        beat(32'hB000_0002, 1'b0);
        beat(32'h002A_88B5, 1'b0);
        reset        = 1'b1;
        SentMinstret = 64'd0;
        @(negedge clk);
        chk_reset_values("midrst");
        reset          = 1'b0;
        rx_if.RxTvalid = 1'b1;
        rx_if.RxTdata  = 32'd0;
        rx_if.RxTlast  = 1'b0;
        beat(32'd0, 1'b0);
        beat(32'd0, 1'b1);
        idle(3);
        chk("t6_tail_bad", {48'd0, BadFrameCount}, 64'd1);
        chk("t6_tail_good", {48'd0, GoodFrameCount}, 64'd0);
        SentMinstret = 64'd43;
        push_exp(64'd43, 32'd0, 16'd1);
        frame(7, 32'h002B_88B5, 32'd0, 32'd0, 32'd0);
        wait_ack("t6");
        idle(2);
        chk("t6_bad_after", {48'd0, BadFrameCount}, 64'd1);
        chk("t6_stall", {63'd0, ExternalStall}, 64'd0);

        // Stall with no acknowledges
        SentMinstret = 64'd107;
`ifdef RVVI_ACK_TIMEOUT_EN
        repeat (12) @(negedge clk);
        chk("to_flag", {63'd0, AckTimeout}, 64'd1);
        chk("to_stall", {63'd0, ExternalStall}, 64'd0);
        chk("to_resync", AckMinstret, 64'd107);
`else
        repeat (20) @(negedge clk);
        chk("to_flag", {63'd0, AckTimeout}, 64'd0);
        chk("to_stall", {63'd0, ExternalStall}, 64'd1);
`endif

        idle(4);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
